cordic_arb_seq: RTL and testbench
=================================

CORDIC_ARB_SEQ -- requirements
Module: cordic_arb_seq

Interface
REQ-001 The block SHALL have parameter NUM_ITER, default 8, giving the CORDIC iterations per operation; legal range is 2..8.
REQ-002 The block SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 has operands ready.
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester 0 operands accepted this cycle.
REQ-006 The block SHALL have port req1_valid, input, 1 bit: requester 1 has operands ready.
REQ-007 The block SHALL have port req1_ready, output, 1 bit: requester 1 operands accepted this cycle.
REQ-008 The block SHALL have port dp_sel, output, 1 bit: datapath operand-mux select (0 = requester 0, 1 = requester 1).
REQ-009 The block SHALL have port dp_load, output, 1 bit: one-cycle strobe that loads the datapath x/y/z registers.
REQ-010 The block SHALL have port dp_step, output, 1 bit: datapath iteration enable.
REQ-011 The block SHALL have port dp_iter, output, 3 bits: iteration index (shift amount / atan ROM address).
REQ-012 The block SHALL have port res_valid, output, 1 bit: the datapath result is final.
REQ-013 The block SHALL have port res_ready, input, 1 bit: the result consumer accepts the result.
REQ-014 The block SHALL have port res_id, output, 1 bit: the requester that owns the current result.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ITER, DONE and spare-illegal; any illegal encoding SHALL return to IDLE.
REQ-017 In IDLE with at least one reqN_valid high, the block SHALL grant one requester and, in the same cycle, assert reqN_ready for that requester only, assert dp_load, drive dp_sel to its id, and latch its id as owner; the next state SHALL be ITER.
REQ-018 Arbitration SHALL be round-robin on last_grant: if both requesters are valid, the grant goes to the requester that is not last_grant; if one is valid, the grant goes to that one; last_grant SHALL update on every grant.
REQ-019 reqN_ready SHALL never be asserted outside IDLE, and SHALL never be asserted when reqN_valid is low.
REQ-020 In ITER, dp_step SHALL be 1 and dp_iter SHALL equal the iteration count, which starts at 0 and increments by 1 per cycle; after the cycle with count = NUM_ITER-1 the next state SHALL be DONE and the count SHALL clear to 0.
REQ-021 dp_step SHALL be asserted for exactly NUM_ITER consecutive cycles per operation; dp_iter SHALL be 0 whenever the FSM is not in ITER.
REQ-022 Latency: if acceptance occurs at cycle T, dp_step SHALL be high in cycles T+1..T+NUM_ITER and res_valid SHALL first be high at cycle T+NUM_ITER+1.
REQ-023 In DONE, res_valid SHALL be 1 and res_id SHALL equal owner; both SHALL hold stable until res_ready is high, and the FSM SHALL then return to IDLE in the next cycle.
REQ-024 No new request SHALL be accepted in DONE, including the cycle in which res_ready is high; minimum spacing between acceptances SHALL be NUM_ITER+2 cycles.
REQ-025 Requests that arrive while busy is high SHALL be held off (ready low) and SHALL NOT be lost or reordered by the block.
REQ-026 For NUM_ITER = 8, the count wrap from 7 to 0 SHALL coincide with the ITER to DONE transition, with no extra dp_step.

Reset
REQ-027 On reset the block SHALL go to IDLE, clear the count to 0, set owner = 0 and last_grant = 1 (so requester 0 wins the first tie), and clear all outputs to 0.
REQ-028 A reset during ITER or DONE SHALL abort the operation: no res_valid SHALL be produced for it, and dp_step SHALL be low in the cycle after reset is sampled.

Structure
REQ-029 Package cordic_pkg SHALL hold ITER_W = 3, the default NUM_ITER, and the FSM state enum.
REQ-030 The iteration count SHALL be a sub-module, cordic_iter_counter (3-bit, with synchronous clear, enable, and a terminal-count flag at NUM_ITER-1).

Verification
REQ-031 Reset, then req0_valid only -> req0_ready and dp_load at T, dp_iter 0..7 in T+1..T+8, res_valid with res_id = 0 at T+9.
REQ-032 req0_valid and req1_valid both held high for three operations -> grants in the order 0, 1, 0, and each reqN_ready pulses once per grant.
REQ-033 res_ready held low for 5 cycles in DONE -> res_valid and res_id stay stable for those 5 cycles; IDLE is entered the cycle after res_ready rises.
REQ-034 reset asserted at dp_iter = 4 -> the next cycle shows busy = 0, dp_step = 0, and no res_valid; the next tie grants requester 0.
REQ-035 NUM_ITER = 2 with back-to-back req1 -> acceptances are exactly 4 cycles apart, with dp_iter sequence 0, 1.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and FSM state encoding for the CORDIC arbiter/sequencer.
package cordic_pkg;
    localparam int ITER_W       = 3;
    localparam int NUM_ITER_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        DONE  = 2'd2,
        SPARE = 2'd3
    } state_e;
endpackage

// File: rtl/cordic_iter_counter.sv
// Iteration counter: synchronous clear, enable, and wrap to 0 on terminal count.
module cordic_iter_counter
    import cordic_pkg::*;
#(
    parameter int NUM_ITER = NUM_ITER_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    output logic [ITER_W-1:0] count,
    output logic              tc
);
    logic [ITER_W-1:0] count_q;
    logic [ITER_W-1:0] count_d;

    assign tc    = (count_q == ITER_W'(NUM_ITER - 1));
    assign count = count_q;

    // Wrapping on tc makes the count land on 0 exactly as the FSM leaves ITER.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + ITER_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/cordic_arb_seq.sv
// Two-requester round-robin arbiter and iteration sequencer for a CORDIC datapath.
module cordic_arb_seq
    import cordic_pkg::*;
#(
    parameter int NUM_ITER = NUM_ITER_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    output logic              dp_sel,
    output logic              dp_load,
    output logic              dp_step,
    output logic [ITER_W-1:0] dp_iter,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic              busy
);
    state_e            state_q;
    state_e            state_d;
    logic              owner_q;
    logic              owner_d;
    logic              last_q;
    logic              last_d;
    logic              grant_id;
    logic [ITER_W-1:0] count;
    logic              tc;

    cordic_iter_counter #(.NUM_ITER(NUM_ITER)) u_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (state_q != ITER),
        .en    (state_q == ITER),
        .count (count),
        .tc    (tc)
    );

    // On a tie the requester that did not win last time is served.
    assign grant_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        dp_sel     = 1'b0;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        dp_iter    = '0;
        res_valid  = 1'b0;
        res_id     = 1'b0;
        busy       = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                // No handshake while reset is asserted: the grant would be discarded.
                if (!reset && (req0_valid || req1_valid)) begin
                    state_d    = ITER;
                    owner_d    = grant_id;
                    last_d     = grant_id;
                    dp_load    = 1'b1;
                    dp_sel     = grant_id;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                end
            end
            ITER: begin
                dp_step = 1'b1;
                dp_iter = count;
                if (tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_id    = owner_q;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_cordic_arb_seq.sv
// Bench for cordic_arb_seq: NUM_ITER=8 and NUM_ITER=2 instances against an operation-level model.
module tb_cordic_arb_seq;
    logic       clock = 1'b0;
    logic       reset;
    logic       v0 [2];
    logic       v1 [2];
    logic       rr [2];
    logic       r0 [2];
    logic       r1 [2];
    logic       sel [2];
    logic       ld [2];
    logic       st [2];
    logic       rv [2];
    logic       rid [2];
    logic       bz [2];
    logic [2:0] it [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Operation-level model: active flag plus cycles elapsed since acceptance.
    int ni [2] = '{8, 2};
    int act [2];
    int k [2];
    int own [2];
    int last [2];
    int pend0 [2];
    int pend1 [2];
    int prev_rv [2];
    int rr_mode [2];
    int arrive_pct;
    logic rst;

    int acc0 [$];
    int gnt0 [$];
    int rvc0 [$];
    int acc1 [$];
    int gnt1 [$];

    always #5 clock = ~clock;

    cordic_arb_seq #(.NUM_ITER(8)) u_dut8 (
        .clock(clock), .reset(reset),
        .req0_valid(v0[0]), .req0_ready(r0[0]),
        .req1_valid(v1[0]), .req1_ready(r1[0]),
        .dp_sel(sel[0]), .dp_load(ld[0]), .dp_step(st[0]), .dp_iter(it[0]),
        .res_valid(rv[0]), .res_ready(rr[0]), .res_id(rid[0]), .busy(bz[0])
    );

    cordic_arb_seq #(.NUM_ITER(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .req0_valid(v0[1]), .req0_ready(r0[1]),
        .req1_valid(v1[1]), .req1_ready(r1[1]),
        .dp_sel(sel[1]), .dp_load(ld[1]), .dp_step(st[1]), .dp_iter(it[1]),
        .res_valid(rv[1]), .res_ready(rr[1]), .res_id(rid[1]), .busy(bz[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle();
        int g, any, n;
        int e_r0, e_r1, e_ld, e_sel, e_st, e_it, e_rv, e_rid, e_bz;
        @(negedge clock);
        reset = rst;
        for (int d = 0; d < 2; d++) begin
            if (arrive_pct > 0) begin
                if ($urandom_range(99) < arrive_pct && pend0[d] < 3) pend0[d]++;
                if ($urandom_range(99) < arrive_pct && pend1[d] < 3) pend1[d]++;
            end
            v0[d] = (pend0[d] > 0);
            v1[d] = (pend1[d] > 0);
            rr[d] = (rr_mode[d] == 0) ? 1'b1 : (rr_mode[d] == 1) ? 1'b0 : 1'($urandom_range(1));
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            n   = ni[d];
            any = (v0[d] || v1[d]) ? 1 : 0;
            g   = (v0[d] && v1[d]) ? 1 - last[d] : (v1[d] ? 1 : 0);
            e_r0 = 0; e_r1 = 0; e_ld = 0; e_sel = 0; e_st = 0;
            e_it = 0; e_rv = 0; e_rid = 0; e_bz = 0;
            if (act[d] == 0) begin
                if (any == 1) begin
                    e_ld  = 1;
                    e_sel = g;
                    e_r0  = (g == 0) ? 1 : 0;
                    e_r1  = g;
                end
            end else if (k[d] <= n) begin
                e_st = 1; e_it = k[d] - 1; e_bz = 1;
            end else begin
                e_rv = 1; e_rid = own[d]; e_bz = 1;
            end
            if (!rst) begin
                chk($sformatf("i%0d req0_ready", d), int'(r0[d]), e_r0);
                chk($sformatf("i%0d req1_ready", d), int'(r1[d]), e_r1);
                chk($sformatf("i%0d dp_load", d), int'(ld[d]), e_ld);
                chk($sformatf("i%0d dp_sel", d), int'(sel[d]), e_sel);
                chk($sformatf("i%0d dp_step", d), int'(st[d]), e_st);
                chk($sformatf("i%0d dp_iter", d), int'(it[d]), e_it);
                chk($sformatf("i%0d res_valid", d), int'(rv[d]), e_rv);
                chk($sformatf("i%0d res_id", d), int'(rid[d]), e_rid);
                chk($sformatf("i%0d busy", d), int'(bz[d]), e_bz);
            end
            // Requesters follow the DUT's handshake; logs record observed behaviour.
            if (r0[d] && v0[d]) pend0[d]--;
            if (r1[d] && v1[d]) pend1[d]--;
            if (ld[d]) begin
                if (d == 0) begin acc0.push_back(cyc); gnt0.push_back(int'(sel[d])); end
                else        begin acc1.push_back(cyc); gnt1.push_back(int'(sel[d])); end
            end
            if (d == 0 && rv[d] && prev_rv[d] == 0) rvc0.push_back(cyc);
            prev_rv[d] = int'(rv[d]);
            if (rst) begin
                act[d] = 0; k[d] = 0; own[d] = 0; last[d] = 1;
            end else if (act[d] == 0) begin
                if (any == 1) begin
                    act[d] = 1; k[d] = 1; own[d] = g; last[d] = g;
                end
            end else if (k[d] <= n) begin
                k[d]++;
            end else if (rr[d]) begin
                act[d] = 0;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        acc0.delete(); gnt0.delete(); rvc0.delete(); acc1.delete(); gnt1.delete();
    endtask

    initial begin
        int found;
        rst = 1'b1;
        arrive_pct = 0;
        for (int d = 0; d < 2; d++) begin
            act[d] = 0; k[d] = 0; own[d] = 0; last[d] = 1;
            pend0[d] = 0; pend1[d] = 0; prev_rv[d] = 0; rr_mode[d] = 0;
            v0[d] = 1'b0; v1[d] = 1'b0; rr[d] = 1'b1;
        end
        reset = 1'b1;

        // Reset state, then a single requester-0 operation.
        do_reset();
        run(2);
        clear_logs();
        pend0[0] = 1;
        run(14);
        chk("single_grants", gnt0.size(), 1);
        if (gnt0.size() == 1 && rvc0.size() >= 1) begin
            chk("single_owner", gnt0[0], 0);
            chk("single_latency", rvc0[0] - acc0[0], 9);
        end else begin
            chk("single_logged", 0, 1);
        end

        // Both requesters waiting: round-robin order 0, 1, 0.
        do_reset();
        clear_logs();
        pend0[0] = 2; pend1[0] = 1;
        run(40);
        chk("rr_count", gnt0.size(), 3);
        if (gnt0.size() == 3) begin
            chk("rr_g0", gnt0[0], 0);
            chk("rr_g1", gnt0[1], 1);
            chk("rr_g2", gnt0[2], 0);
        end

        // Consumer stalls in DONE.
        clear_logs();
        rr_mode[0] = 1;
        pend1[0] = 1;
        run(15);
        rr_mode[0] = 0;
        run(3);
        chk("stall_busy_after", int'(bz[0]), 0);

        // Reset in the middle of the iterations aborts the operation.
        pend0[0] = 1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            cycle();
            if (st[0] && it[0] == 3'd3) found = 1;
        end
        chk("reach_iter3", found, 1);
        rst = 1'b1;
        cycle();
        chk("abort_iter_at_reset", int'(it[0]), 4);
        rst = 1'b0;
        cycle();
        clear_logs();
        pend0[0] = 1; pend1[0] = 1;
        run(12);
        chk("post_reset_rv_count", rvc0.size(), 1);
        if (gnt0.size() >= 1) chk("post_reset_tie", gnt0[0], 0);
        else chk("post_reset_grant", 0, 1);
        run(12);

        // NUM_ITER=2 back-to-back requester 1.
        clear_logs();
        pend1[1] = 3;
        run(16);
        chk("n2_count", acc1.size(), 3);
        if (acc1.size() == 3) begin
            chk("n2_gap0", acc1[1] - acc1[0], 4);
            chk("n2_gap1", acc1[2] - acc1[1], 4);
            chk("n2_owner", gnt1[0], 1);
        end

        // Random traffic and back-pressure on both instances.
        rr_mode[0] = 2; rr_mode[1] = 2;
        arrive_pct = 30;
        run(2000);
        arrive_pct = 0;
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
